// File: rtl/axi_lite_vram_slave.sv
// axi_lite_vram_slave: AXI4-Lite responder mapping a word window onto a VRAM BRAM and an 8-entry palette
// Ports:
//   axi_aclk, axi_aresetn       bus/block clock, asynchronous active-low reset
//   axi_aw*, axi_w*, axi_b*     write address, write data and write response channels
//   axi_ar*, axi_r*             read address and read data channels (axi_*prot ignored)
//   bram_addr/we/din, bram_dout single BRAM port, 1-cycle read latency, shared by reads and writes
//   palette                     8 x 32-bit entries, entry k at [32k+31:32k]
module axi_lite_vram_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_WORDS       = 1200,
  parameter int PALETTE_BASE     = 'h800,
  parameter int BRAM_ADDR_WIDTH  = 11
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic [C_AXI_DATA_WIDTH/8-1:0] bram_we,
  output logic [C_AXI_DATA_WIDTH-1:0]   bram_din,
  input  logic [C_AXI_DATA_WIDTH-1:0]   bram_dout,
  output logic [8*C_AXI_DATA_WIDTH-1:0] palette
);
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = C_AXI_ADDR_WIDTH - 2;
  localparam logic [IW-1:0] VW = IW'(VRAM_WORDS);
  localparam logic [IW-1:0] PB = IW'(PALETTE_BASE);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT, RD_RESP} rd_state_e;

  rd_state_e         rd_q, rd_d;
  logic              aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [IW-1:0]     aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
  logic [DW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic              rd_prio_q, rd_prio_d;
  logic [7:0][DW-1:0] pal_q, pal_d;

  logic [IW-1:0] wr_off, rd_off;
  logic wr_vram, wr_pal, rd_vram, rd_pal;
  logic wr_req, rd_req, wr_go, rd_go, wr_port, rd_port;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_ok;

  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  // Palette decode relies on unsigned wrap: indices below the base wrap to large offsets.
  assign wr_off  = aw_idx_q - PB;
  assign rd_off  = ar_idx_q - PB;
  assign wr_vram = aw_idx_q < VW;
  assign rd_vram = ar_idx_q < VW;
  assign wr_pal  = wr_off < IW'(8);
  assign rd_pal  = rd_off < IW'(8);

  // Only VRAM targets contend for the port; a write wins unless the read lost last cycle.
  assign wr_req  = aw_lat_q && w_lat_q;
  assign rd_req  = rd_q == RD_ISSUE;
  assign wr_go   = wr_req && !(wr_vram && rd_req && rd_vram && rd_prio_q);
  assign rd_go   = rd_req && !(rd_vram && wr_req && wr_vram && !rd_prio_q);
  assign wr_port = wr_go && wr_vram;
  assign rd_port = rd_go && rd_vram;

  assign aw_hs = axi_awvalid && awready_q;
  assign w_hs  = axi_wvalid && wready_q;
  assign b_hs  = bvalid_q && axi_bready;
  assign ar_hs = axi_arvalid && arready_q;
  assign r_hs  = rvalid_q && axi_rready;

  // Port outputs decode straight from registers so they clear the instant reset asserts.
  assign bram_we   = wr_port ? wstrb_q : '0;
  assign bram_din  = wr_port ? wdata_q : '0;
  assign bram_addr = wr_port ? aw_idx_q[BRAM_ADDR_WIDTH-1:0] :
                     rd_port ? ar_idx_q[BRAM_ADDR_WIDTH-1:0] : '0;

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign palette     = pal_q;

  always_comb begin
    aw_lat_d  = wr_go ? 1'b0 : aw_hs ? 1'b1 : aw_lat_q;
    w_lat_d   = wr_go ? 1'b0 : w_hs ? 1'b1 : w_lat_q;
    aw_idx_d  = aw_hs ? axi_awaddr[C_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
    wdata_d   = w_hs ? axi_wdata : wdata_q;
    wstrb_d   = w_hs ? axi_wstrb : wstrb_q;
    bvalid_d  = wr_go ? 1'b1 : b_hs ? 1'b0 : bvalid_q;
    bresp_d   = wr_go ? ((wr_vram || wr_pal) ? OKAY : SLVERR) : bresp_q;
    awready_d = !aw_lat_d && !bvalid_d;
    wready_d  = !w_lat_d && !bvalid_d;
    rd_prio_d = rd_req && rd_vram && !rd_go;
    pal_d     = pal_q;
    if (wr_go && wr_pal)
      for (int k = 0; k < SW; k++)
        if (wstrb_q[k]) pal_d[wr_off[2:0]][8*k +: 8] = wdata_q[8*k +: 8];
    rd_d      = rd_q;
    ar_idx_d  = ar_idx_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    case (rd_q)
      RD_IDLE: begin
        rd_d     = ar_hs ? RD_ISSUE : RD_IDLE;
        ar_idx_d = ar_hs ? axi_araddr[C_AXI_ADDR_WIDTH-1:2] : ar_idx_q;
      end
      RD_ISSUE: rd_d = rd_go ? RD_WAIT : RD_ISSUE;
      RD_WAIT: begin
        rdata_d  = rd_vram ? bram_dout : rd_pal ? pal_q[rd_off[2:0]] : '0;
        rresp_d  = (rd_vram || rd_pal) ? OKAY : SLVERR;
        rvalid_d = 1'b1;
        rd_d     = RD_RESP;
      end
      RD_RESP: begin
        rvalid_d = !r_hs;
        rd_d     = r_hs ? RD_IDLE : RD_RESP;
      end
      default: rd_d = RD_IDLE;
    endcase
    arready_d = rd_d == RD_IDLE;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      rd_q      <= RD_IDLE;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      aw_idx_q  <= '0;
      ar_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rd_prio_q <= 1'b0;
      pal_q     <= '0;
    end else begin
      rd_q      <= rd_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      aw_idx_q  <= aw_idx_d;
      ar_idx_q  <= ar_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      rd_prio_q <= rd_prio_d;
      pal_q     <= pal_d;
    end
endmodule

// File: tb/tb_axi_lite_vram_slave.sv
// tb_axi_lite_vram_slave: randomized self-checking bench against an address-map reference model
module tb_axi_lite_vram_slave;
  logic clk, rst_n;
  logic [15:0] axi_awaddr, axi_araddr;
  logic [2:0] axi_awprot, axi_arprot;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [31:0] axi_wdata, axi_rdata, bram_din, bram_dout;
  logic [3:0] axi_wstrb, bram_we;
  logic [1:0] axi_bresp, axi_rresp;
  logic [10:0] bram_addr;
  logic [255:0] palette;

  axi_lite_vram_slave dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .palette(palette)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [31:0] bram_mem [2048];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bram_we[k]) bram_mem[bram_addr][8*k +: 8] <= bram_din[8*k +: 8];
    bram_dout <= bram_mem[bram_addr];
  end

  int wr_cnt = 0, bv_rise = 0;
  logic [10:0] last_addr;
  logic [3:0] last_we;
  logic bv_prev = 0;
  always @(negedge clk) begin
    if (bram_we != 0) begin
      wr_cnt = wr_cnt + 1;
      last_addr = bram_addr;
      last_we = bram_we;
    end
    if (axi_bvalid && !bv_prev) bv_rise = bv_rise + 1;
    bv_prev = axi_bvalid;
  end

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_vram [1200];
  logic [31:0] exp_pal [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cls(input logic [15:0] a);
    int w;
    w = int'(a) >> 2;
    if (w < 1200) return 0;
    if (w >= 2048 && w < 2056) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [15:0] a);
    return cls(a) == 2 ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_data(input logic [15:0] a);
    int w;
    w = int'(a) >> 2;
    if (cls(a) == 0) return exp_vram[w];
    if (cls(a) == 1) return exp_pal[w - 2048];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = int'(a) >> 2;
    for (int k = 0; k < 4; k++)
      if (s[k]) begin
        if (cls(a) == 0) exp_vram[w][8*k +: 8] = d[8*k +: 8];
        if (cls(a) == 1) exp_pal[w - 2048][8*k +: 8] = d[8*k +: 8];
      end
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int hold);
    int cyc;
    bit aw_done, w_done, aw_f, w_f;
    logic [1:0] resp;
    cyc = 0; aw_done = 0; w_done = 0;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      axi_awvalid = !aw_done && cyc >= (lead > 0 ? lead : 0);
      axi_wvalid = !w_done && cyc >= (lead < 0 ? -lead : 0);
      @(negedge clk);
      aw_f = axi_awvalid && axi_awready;
      w_f = axi_wvalid && axi_wready;
      @(posedge clk); #1;
      aw_done |= aw_f; w_done |= w_f; cyc++;
    end
    axi_awvalid = 0; axi_wvalid = 0;
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    cyc = 0;
    while (!axi_bvalid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bvalid_seen", axi_bvalid, 1);
    resp = axi_bresp;
    for (int h = 0; h < hold; h++) begin
      chk("b_hold", {axi_bvalid, axi_bresp, axi_awready, axi_wready}, {1'b1, resp, 2'b00});
      @(posedge clk); #1;
    end
    axi_bready = 1;
    @(posedge clk); #1;
    axi_bready = 0;
    chk("bresp", resp, exp_resp(a));
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [15:0] a, input int hold);
    int cyc, lat;
    bit fire;
    logic [31:0] rd;
    logic [1:0] rr;
    axi_araddr = a; axi_arvalid = 1; cyc = 0; fire = 0;
    while (!fire && cyc < 50) begin
      @(negedge clk);
      fire = axi_arvalid && axi_arready;
      @(posedge clk); #1;
      cyc++;
    end
    axi_arvalid = 0;
    chk("ar_handshake", fire, 1);
    lat = 0;
    while (!axi_rvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("rd_latency", lat, 2);
    rd = axi_rdata; rr = axi_rresp;
    for (int h = 0; h < hold; h++) begin
      chk("r_hold", {axi_rvalid, axi_rdata, axi_rresp, axi_arready}, {1'b1, rd, rr, 1'b0});
      @(posedge clk); #1;
    end
    axi_rready = 1;
    @(posedge clk); #1;
    axi_rready = 0;
    chk("rdata", rd, exp_data(a));
    chk("rresp", rr, exp_resp(a));
  endtask

  initial begin
    int base, bvb, w;
    logic [31:0] d;
    logic [15:0] a;
    for (int i = 0; i < 1200; i++) exp_vram[i] = 0;
    for (int i = 0; i < 8; i++) exp_pal[i] = 0;
    rst_n = 0;
    axi_awaddr = 0; axi_araddr = 0; axi_awprot = 0; axi_arprot = 0;
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
    axi_wdata = 0; axi_wstrb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, bram_we}, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_bram", {bram_addr, bram_din}, 0);
    chk("rst_palette", |palette, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_rise", {axi_awready, axi_wready, axi_arready}, 3'b111);

    for (int i = 0; i < 1200; i++) begin
      do_write(16'(4 * i), 32'(i), 4'hF, $urandom_range(0, 4) - 2, 0);
      do_read(16'(4 * i), 0);
    end

    base = wr_cnt; bvb = bv_rise;
    do_write(16'h10, 32'hDEADBEEF, 4'hF, 3, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("wlead_commits", wr_cnt - base, 1);
    chk("wlead_bram", {last_addr, last_we}, {11'd4, 4'hF});
    chk("wlead_bvalids", bv_rise - bvb, 1);
    do_read(16'h10, 0);

    do_write(16'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(16'h20, 32'h00000000, 4'b0101, 0, 0);
    do_read(16'h20, 0);
    chk("strobe_value", exp_data(16'h20), 32'hFF00FF00);

    base = wr_cnt;
    do_write(16'h200C, 32'h01234567, 4'hF, 0, 0);
    chk("pal_entry3", palette[127:96], 32'h01234567);
    do_read(16'h200C, 0);
    chk("pal_no_bram", wr_cnt - base, 0);
    do_write(16'(4 * 1200), 32'h12345678, 4'hF, 0, 0);
    do_read(16'(4 * 1200), 0);
    do_write(16'h2000 + 16'h10 * 0 + 16'h0, 32'hA5A5A5A5, 4'h0, 0, 0);
    chk("pal_zero_strobe", palette[31:0], 32'h0);

    d = $urandom;
    axi_awaddr = 16'h80; axi_wdata = d; axi_wstrb = 4'hF; axi_araddr = 16'h40;
    axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    @(negedge clk);
    chk("ct_ready", {axi_awready, axi_wready, axi_arready}, 3'b111);
    @(posedge clk); #1;
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    @(negedge clk);
    chk("ct_write_first", {bram_we, bram_addr}, {4'hF, 11'h20});
    @(negedge clk);
    chk("ct_read_next", {bram_we, bram_addr}, {4'h0, 11'h10});
    @(posedge clk); #1;
    chk("ct_rvalid_early", axi_rvalid, 0);
    @(posedge clk); #1;
    chk("ct_rvalid_lat3", axi_rvalid, 1);
    chk("ct_rdata", {axi_rdata, axi_rresp}, {exp_data(16'h40), 2'b00});
    chk("ct_bvalid", {axi_bvalid, axi_bresp}, 3'b100);
    axi_rready = 1; axi_bready = 1;
    @(posedge clk); #1;
    axi_rready = 0; axi_bready = 0;
    model_write(16'h80, d, 4'hF);
    do_read(16'h80, 0);

    do_write(16'h44, $urandom, 4'hF, 0, 5);
    do_read(16'h44, 5);
    do_write(16'hFFFC, $urandom, 4'hF, 0, 5);
    do_read(16'h2004, 5);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: w = $urandom_range(0, 1199);
        6: w = 2048 + $urandom_range(0, 7);
        7: w = 1199 + $urandom_range(0, 1);
        default: w = $urandom_range(1200, 16383);
      endcase
      a = 16'(w * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    do_write(16'h2008, 32'hCAFEF00D, 4'hF, 0, 0);
    do_write(16'h100, 32'h5A5A1234, 4'hF, 0, 0);
    axi_araddr = 16'h100; axi_arvalid = 1;
    @(posedge clk); #1;
    axi_arvalid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rvalid", {axi_rvalid, axi_rdata}, {1'b1, 32'h5A5A1234});
    #3 rst_n = 0;
    #1;
    chk("arst_ctrl", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, bram_we}, 0);
    chk("arst_rdata", axi_rdata, 0);
    chk("arst_palette", |palette, 0);
    for (int i = 0; i < 8; i++) exp_pal[i] = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("arst_ready_rise", {axi_awready, axi_wready, axi_arready}, 3'b111);
    do_read(16'h2008, 0);
    do_read(16'h100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_vram_slave.md
Name: axi_lite_vram_slave

Overview:
AXI4-Lite responder that terminates the host bus inside hdmi_text_controller. It maps a byte-addressed window onto two targets: a single-port VRAM BRAM (1 cycle read latency), and an 8-entry palette register file that the draw logic reads.
Writes honour byte strobes. Unmapped accesses complete with SLVERR. Reads and writes share the one BRAM port under fixed arbitration.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_AXI_ADDR_WIDTH, 16, byte address width; word index = addr[C_AXI_ADDR_WIDTH-1:2]
VRAM_WORDS, 1200, word indices 0..VRAM_WORDS-1 map to BRAM
PALETTE_BASE, 'h800, word index of palette entry 0; entries PALETTE_BASE..PALETTE_BASE+7
BRAM_ADDR_WIDTH, 11, BRAM word address width

Ports:
axi_aclk  in  1  bus and block clock
axi_aresetn  in  1  asynchronous active-low reset
axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
axi_awprot  in  3  ignored
axi_awvalid / axi_awready  in / out  1  AW handshake
axi_wdata  in  32  write data
axi_wstrb  in  4  byte strobes
axi_wvalid / axi_wready  in / out  1  W handshake
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bvalid / axi_bready  out / in  1  B handshake
axi_araddr  in  C_AXI_ADDR_WIDTH  read address
axi_arprot  in  3  ignored
axi_arvalid / axi_arready  in / out  1  AR handshake
axi_rdata  out  32  read data
axi_rresp  out  2  00 OKAY, 10 SLVERR
axi_rvalid / axi_rready  out / in  1  R handshake
bram_addr  out  BRAM_ADDR_WIDTH  BRAM word address
bram_we  out  4  BRAM byte write enables
bram_din  out  32  BRAM write data
bram_dout  in  32  BRAM read data, valid 1 cycle after address
palette  out  256  entry k at bits [32k+31:32k]

Behaviour:
- Reset (async assert, sync release):
  - All ready/valid outputs are 0.
  - rdata, bresp, rresp, bram_we, bram_addr, bram_din and palette are 0.
  - awready, wready and arready rise on the first clock edge after release.
- Write channel:
  - AW and W are accepted independently, in either order or together.
  - awready=1 only while no address is latched and bvalid=0. Same rule for wready with respect to latched data.
  - Each ready drops on the edge its handshake completes.
  - Once both AW and W are latched, the write commits in the next cycle the BRAM port is granted:
    - VRAM target: bram_we=wstrb and bram_addr=word index.
    - Palette target: per-byte update of the register, no BRAM access.
    - Unmapped target: no side effect, bresp=10.
  - bvalid rises the edge after commit and is held with bresp stable until bready. Both readies re-assert the edge after the B handshake.
  - wstrb=0 is a legal no-op with OKAY.
- Read channel:
  - arready=1 only in RD_IDLE. The AR handshake latches the address, drops arready, and moves to RD_ISSUE.
  - RD_ISSUE: drive bram_addr when granted (stay here if not), then go to RD_WAIT.
  - RD_WAIT: capture bram_dout, palette value, or 0 into rdata, set rvalid=1, go to RD_RESP.
  - RD_RESP: hold rdata, rresp and rvalid until rready, then return to RD_IDLE with arready=1 on the next edge.
  - Uncontended latency: rvalid is high 2 cycles after the AR handshake edge. Palette and unmapped reads use the same timing; unmapped reads return 0 with rresp=10.
- Arbitration:
  - If a write commit and a read issue want the BRAM port in the same cycle, the write wins.
  - After a write win, the pending read has guaranteed grant on the next cycle, even if another write is ready.
  - Palette and unmapped accesses never request the port.
- Boundaries:
  - Word VRAM_WORDS-1 maps to VRAM; word VRAM_WORDS is unmapped.
  - Address bits [1:0] are ignored.
  - Word indices beyond the address width never alias.
  - Read-after-write to the same word returns the new data once bvalid has been seen.
- Reset mid-transaction aborts everything. No partial write may occur after reset assertion, because bram_we clears asynchronously.

Test Plan:
- Write 4*i→i for i=0..1199, reading back each → bresp=00, rdata=i, rresp=00; rvalid 2 cycles after AR handshake.
- W presented 3 cycles before AW (addr 0x10, data 0xDEADBEEF) → single commit of bram_we=F at addr 4, exactly one bvalid.
- Byte strobe: write 0xFFFFFFFF then 0x00000000 with wstrb=0101 to addr 0x20 → readback 0xFF00FF00.
- Palette: write 0x01234567 to byte 0x2000+4*3 → palette[127:96]=0x01234567, readback OKAY with no BRAM activity; write to byte 4*1200 → bresp=10, read → rdata=0, rresp=10.
- Contention: AR and the completing AW/W land on the same cycle (addr 0x40 read, 0x80 write) → write commits first, read issues the next cycle, rvalid 3 cycles after AR handshake.
- Hold bready/rready low for 5 cycles → bvalid, rvalid and data stay stable and no new AW/W/AR is accepted. Assert axi_aresetn low mid-read → all outputs return to reset values immediately.
